// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between instruction
// fetch (IF) and the data-memory stage (DM); one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [LINE_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [LINE_WIDTH-1:0] dm_wdata,
  output logic [LINE_WIDTH-1:0] dm_rdata,
  output logic                  dm_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {REQ_IF = 1'b0, REQ_DM = 1'b1} requester_t;

  state_t     state, state_next;
  // Owner of the in-flight transaction; also the round-robin history.
  requester_t last_grant;
  logic       start_if, start_dm;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    start_if   = 1'b0;
    start_dm   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (dm_req && (!if_req || last_grant == REQ_IF)) begin
          start_dm   = 1'b1;
          state_next = ACCESS;
        end else if (if_req) begin
          start_if   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      busy    <= (state_next != IDLE);

      if (start_dm) begin
        last_grant <= REQ_DM;
        mem_req    <= 1'b1;
        mem_we     <= dm_we;
        mem_addr   <= dm_addr;
        mem_wdata  <= dm_wdata;
      end else if (start_if) begin
        last_grant <= REQ_IF;
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
      end

      // Completion: done is raised on entry to RESP, so it lasts one cycle.
      if (state == ACCESS && mem_ready) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (last_grant == REQ_DM) begin
          dm_done <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
